// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scan_ctrl
//  Purpose  : Multiplexed 7-segment display driver. Time-slices N_DIGITS
//             hex/BCD digits onto one segment bus with per-digit enables,
//             decimal points, hex glyphs, leading-zero blanking, PWM
//             brightness, anti-ghost dead time and frame-synchronous capture.
//  Revision : 1.0  initial release
// ============================================================================
module seven_seg_scan_ctrl #(
    parameter int N_DIGITS       = 8,
    parameter int REFRESH_DIV    = 100000,
    parameter int DEAD_CYCLES    = 16,
    parameter int BRIGHT_W       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   digit,
    output logic                  frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0]    c_CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]    c_DEAD     = CNT_W'(DEAD_CYCLES);
    localparam logic [SEL_W-1:0]    c_SEL_MAX  = SEL_W'(N_DIGITS - 1);
    localparam logic [6:0]          c_SEG_OFF  = {7{SEG_ACTIVE_LOW}};
    localparam logic                c_DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [N_DIGITS-1:0] c_DIG_OFF  = {N_DIGITS{AN_ACTIVE_LOW}};

    logic [CNT_W-1:0]      r_slot_cnt;
    logic [SEL_W-1:0]      r_sel;
    logic [4*N_DIGITS-1:0] r_sh_digits;
    logic [N_DIGITS-1:0]   r_sh_dp;
    logic                  r_sh_hex;
    logic                  r_sh_blz;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [N_DIGITS-1:0]   r_digit;
    logic                  r_frame_tick;

    logic                  w_slot_wrap;
    logic                  w_frame_wrap;
    logic                  w_load;
    logic [BRIGHT_W-1:0]   w_phase;
    logic                  w_pwm_on;
    logic [3:0]            w_cur_val;
    logic [N_DIGITS-1:0]   w_zero_from;
    logic                  w_blank;
    logic                  w_lit;
    logic [6:0]            w_glyph;

    assign w_slot_wrap  = (r_slot_cnt == c_CNT_MAX);
    assign w_frame_wrap = w_slot_wrap && (r_sel == c_SEL_MAX);
    // Inputs are frozen for a whole frame so a multi-digit value never tears;
    // while scanning is off the shadow simply tracks the inputs.
    assign w_load       = !en || w_frame_wrap;

    // Slot counter and digit selector; both parked at 0 while disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot_cnt <= '0;
            r_sel      <= '0;
        end else if (!en) begin
            r_slot_cnt <= '0;
            r_sel      <= '0;
        end else if (w_slot_wrap) begin
            r_slot_cnt <= '0;
            r_sel      <= (r_sel == c_SEL_MAX) ? '0 : r_sel + 1'b1;
        end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end
    end

    // Shadow copy of the display content, updated only at frame boundaries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh_digits <= '0;
            r_sh_dp     <= '0;
            r_sh_hex    <= 1'b0;
            r_sh_blz    <= 1'b0;
        end else if (w_load) begin
            r_sh_digits <= digits;
            r_sh_dp     <= dp_in;
            r_sh_hex    <= hex_mode;
            r_sh_blz    <= blank_lz;
        end
    end

    // Leading-zero detection: bit i set when digits i..N_DIGITS-1 are all zero.
    always_comb begin
        logic w_acc;
        w_acc       = 1'b1;
        w_zero_from = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            w_acc          = w_acc && (r_sh_digits[4*i +: 4] == 4'd0);
            w_zero_from[i] = w_acc;
        end
    end

    assign w_phase   = r_slot_cnt[BRIGHT_W-1:0];
    assign w_pwm_on  = (w_phase < brightness) || (&brightness);
    assign w_cur_val = r_sh_digits[4*r_sel +: 4];
    assign w_blank   = r_sh_blz && (r_sel != '0) && w_zero_from[r_sel];
    assign w_lit     = en && (r_slot_cnt >= c_DEAD) && w_pwm_on && !w_blank;

    // Glyph ROM, active-high {a,b,c,d,e,f,g}; letters only in hex mode.
    always_comb begin
        w_glyph = 7'b0000000;
        case (w_cur_val)
            4'h0: w_glyph = 7'b1111110;
            4'h1: w_glyph = 7'b0110000;
            4'h2: w_glyph = 7'b1101101;
            4'h3: w_glyph = 7'b1111001;
            4'h4: w_glyph = 7'b0110011;
            4'h5: w_glyph = 7'b1011011;
            4'h6: w_glyph = 7'b1011111;
            4'h7: w_glyph = 7'b1110000;
            4'h8: w_glyph = 7'b1111111;
            4'h9: w_glyph = 7'b1111011;
            4'hA: w_glyph = r_sh_hex ? 7'b1110111 : 7'b0000000;
            4'hB: w_glyph = r_sh_hex ? 7'b0011111 : 7'b0000000;
            4'hC: w_glyph = r_sh_hex ? 7'b1001110 : 7'b0000000;
            4'hD: w_glyph = r_sh_hex ? 7'b0111101 : 7'b0000000;
            4'hE: w_glyph = r_sh_hex ? 7'b1001111 : 7'b0000000;
            4'hF: w_glyph = r_sh_hex ? 7'b1000111 : 7'b0000000;
            default: w_glyph = 7'b0000000;
        endcase
    end

    // Registered pin drivers; everything dark unless the current slot is lit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seg        <= c_SEG_OFF;
            r_dp         <= c_DP_OFF;
            r_digit      <= c_DIG_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= en && w_frame_wrap;
            if (w_lit) begin
                r_seg   <= w_glyph ^ c_SEG_OFF;
                r_dp    <= r_sh_dp[r_sel] ^ c_DP_OFF;
                r_digit <= (N_DIGITS'(1) << r_sel) ^ c_DIG_OFF;
            end else begin
                r_seg   <= c_SEG_OFF;
                r_dp    <= c_DP_OFF;
                r_digit <= c_DIG_OFF;
            end
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign digit      = r_digit;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_seg_scan_ctrl
//  Purpose  : Self-checking bench for seven_seg_scan_ctrl (3 digits, 8-cycle
//             slots, 2 dead cycles, 2-bit brightness, active-low pins).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;

    localparam int N    = 3;
    localparam int RD   = 8;
    localparam int DEAD = 2;
    localparam int BW   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [11:0] digits;
    logic [2:0]  dp_in;
    logic        hex_mode;
    logic        blank_lz;
    logic [1:0]  brightness;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  digit;
    logic        frame_tick;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: position within the frame and the captured frame.
    int          m_t;
    logic [11:0] m_dig;
    logic [2:0]  m_dp;
    logic        m_hex;
    logic        m_blz;
    logic [6:0]  glyph [16];

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(
        .N_DIGITS      (N),
        .REFRESH_DIV   (RD),
        .DEAD_CYCLES   (DEAD),
        .BRIGHT_W      (BW),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .digits    (digits),
        .dp_in     (dp_in),
        .hex_mode  (hex_mode),
        .blank_lz  (blank_lz),
        .brightness(brightness),
        .seg       (seg),
        .dp        (dp),
        .digit     (digit),
        .frame_tick(frame_tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_t   = 0;
        m_dig = '0;
        m_dp  = '0;
        m_hex = 1'b0;
        m_blz = 1'b0;
    endtask

    task automatic capture();
        m_dig = digits;
        m_dp  = dp_in;
        m_hex = hex_mode;
        m_blz = blank_lz;
    endtask

    // Predict one clock edge from the display rules, advance, then compare.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            int         slot, pos, val;
            bit         lit, tick;
            logic [6:0] e_seg;
            logic       e_dp;
            logic [2:0] e_digit;
            lit  = 1'b0;
            tick = 1'b0;
            slot = m_t / RD;
            pos  = m_t % RD;
            val  = int'((m_dig >> (4 * slot)) & 12'hF);
            if (en) begin
                lit = (pos >= DEAD)
                   && (((pos % (1 << BW)) < int'(brightness)) || (brightness == 2'b11))
                   && !(m_blz && slot != 0 && (m_dig >> (4 * slot)) == 12'd0);
            end
            e_seg   = 7'h7F;
            e_dp    = 1'b1;
            e_digit = 3'b111;
            if (lit) begin
                e_seg   = (val >= 10 && !m_hex) ? 7'h7F : ~glyph[val];
                e_dp    = ~m_dp[slot];
                e_digit = ~(3'b001 << slot);
            end
            if (!en) begin
                m_t = 0;
                capture();
            end else begin
                tick = (m_t == N * RD - 1);
                if (tick) capture();
                m_t = (m_t + 1) % (N * RD);
            end
            @(posedge clk);
            #1;
            check("seg", 32'(seg), 32'(e_seg));
            check("dp", 32'(dp), 32'(e_dp));
            check("digit", 32'(digit), 32'(e_digit));
            check("frame_tick", 32'(frame_tick), 32'(tick));
        end
    endtask

    initial begin
        glyph[0]  = 7'b1111110; glyph[1]  = 7'b0110000; glyph[2]  = 7'b1101101;
        glyph[3]  = 7'b1111001; glyph[4]  = 7'b0110011; glyph[5]  = 7'b1011011;
        glyph[6]  = 7'b1011111; glyph[7]  = 7'b1110000; glyph[8]  = 7'b1111111;
        glyph[9]  = 7'b1111011; glyph[10] = 7'b1110111; glyph[11] = 7'b0011111;
        glyph[12] = 7'b1001110; glyph[13] = 7'b0111101; glyph[14] = 7'b1001111;
        glyph[15] = 7'b1000111;

        // Reset state
        rst = 1'b0; en = 1'b0; digits = '0; dp_in = '0;
        hex_mode = 1'b0; blank_lz = 1'b0; brightness = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_digit", 32'(digit), 32'h7);
        check("rst_tick", 32'(frame_tick), 32'h0);
        rst = 1'b1;

        // 321 at full brightness
        digits = 12'h321; brightness = 2'd3; dp_in = 3'b010;
        step(1);
        en = 1'b1;
        step(4);
        check("lit_d0_digit", 32'(digit), 32'h6);
        check("lit_d0_seg", 32'(seg), 32'(7'h7F & ~7'b0110000));
        step(8);
        check("lit_d1_digit", 32'(digit), 32'h5);
        check("lit_d1_seg", 32'(seg), 32'(7'h7F & ~7'b1101101));
        step(8);
        check("lit_d2_digit", 32'(digit), 32'h3);
        check("lit_d2_seg", 32'(seg), 32'(7'h7F & ~7'b1111001));
        step(4);
        check("tick_at_24", 32'(frame_tick), 32'h1);
        step(27);

        // Reset mid-scan while digit 0 is lit
        #2;
        check("pre_rst_lit", 32'(digit), 32'h6);
        rst = 1'b0;
        #1;
        check("async_rst_digit", 32'(digit), 32'h7);
        check("async_rst_seg", 32'(seg), 32'h7F);
        check("async_rst_dp", 32'(dp), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        step(30);

        // PWM: brightness 1 then 0
        brightness = 2'd1;
        step(24);
        brightness = 2'd0;
        step(24);
        brightness = 2'd3;

        // Leading-zero blanking
        en = 1'b0; blank_lz = 1'b1; digits = 12'h005; dp_in = 3'b000;
        step(1);
        en = 1'b1;
        step(24);
        en = 1'b0; digits = 12'h000;
        step(1);
        en = 1'b1;
        step(24);

        // Hex mode off/on for code B
        en = 1'b0; blank_lz = 1'b0; hex_mode = 1'b0; digits = 12'h00B;
        step(1);
        en = 1'b1;
        step(5);
        check("nonhex_b_seg", 32'(seg), 32'h7F);
        check("nonhex_b_digit", 32'(digit), 32'h6);
        en = 1'b0; hex_mode = 1'b1;
        step(1);
        en = 1'b1;
        step(5);
        check("hex_b_seg", 32'(seg), 32'(7'h7F & ~7'b0011111));

        // Mid-frame change: rest of frame keeps old value
        en = 1'b0; hex_mode = 1'b0; digits = 12'h111;
        step(1);
        en = 1'b1;
        step(10);
        digits = 12'h222;
        step(4);
        check("midframe_old", 32'(seg), 32'(7'h7F & ~7'b0110000));
        step(34);

        // Randomized run
        for (int r = 0; r < 60; r++) begin
            if ($urandom_range(3) == 0) digits = 12'($urandom);
            if ($urandom_range(3) == 0) dp_in = 3'($urandom);
            if ($urandom_range(4) == 0) hex_mode = 1'($urandom);
            if ($urandom_range(4) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(4) == 0) brightness = 2'($urandom);
            en = ($urandom_range(9) != 0);
            step(int'($urandom_range(1, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
